gol_led_scan: RTL and testbench

//  Downstream display stage for the 8x8 Game-of-Life core. Captures each 64-bit generation
//  and time-multiplexes it onto an 8x8 LED matrix one row at a time.

---
 rtl/gol_pkg.sv | 22 ++
 rtl/gol_led_scan_if.sv | 15 +
 rtl/gol_scan_prescaler.sv | 29 ++
 rtl/gol_led_scan.sv | 121 ++++++++++++
 tb/tb_gol_led_scan.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/gol_pkg.sv
// Shared types and helpers for the Game-of-Life LED scan stage.
package gol_pkg;

  localparam int GRID_W = 64;
  localparam int ROW_W  = 8;

  typedef logic [GRID_W-1:0] grid_t;
  typedef logic [ROW_W-1:0]  row_t;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_t;

  // Row r lives in bits 63-8r down to 56-8r; 63-8r is simply {~r, 3'b111}.
  function automatic row_t grid_row(grid_t g, logic [2:0] r);
    logic [5:0] top;
    top = {~r, 3'b111};
    return g[top -: ROW_W];
  endfunction

endpackage

// File: rtl/gol_led_scan_if.sv
// Generation input and LED matrix output bundle between the GoL core, the scanner and the board.
interface gol_led_scan_if;
  import gol_pkg::*;

  grid_t grid_in;
  logic  grid_valid;
  row_t  row_out;
  row_t  col_out;
  logic  frame_done;
  logic  stable;

  modport master (output grid_in, grid_valid, input row_out, col_out, frame_done, stable);
  modport slave  (input grid_in, grid_valid, output row_out, col_out, frame_done, stable);

endinterface

// File: rtl/gol_scan_prescaler.sv
// Row-slot prescaler: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module gol_scan_prescaler #(
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign tick  = (count_reg == LAST);

endmodule

// File: rtl/gol_led_scan.sv
// 8x8 LED matrix scanner for the GoL core: per-row blanking, frame-synchronous generation swap.
// Optional feature macro: GOL_STABLE_DETECT_EN (reports whether the last update left the grid unchanged).
module gol_led_scan
  import gol_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 0
) (
  input logic           clk,
  input logic           reset,
  gol_led_scan_if.slave bus
);

  localparam int               CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam row_t             ROW_IDLE   = (ROW_ACTIVE_LOW != 0) ? {ROW_W{1'b1}} : {ROW_W{1'b0}};
  localparam row_t             COL_IDLE   = (COL_ACTIVE_LOW != 0) ? {ROW_W{1'b1}} : {ROW_W{1'b0}};

  logic [CNT_W-1:0] count;
  logic             tick;
  scan_state_t      state_reg, state_next;
  logic [2:0]       row_idx_reg;
  grid_t            disp_grid_reg, pend_grid_reg, update_grid;
  logic             pending_reg, frame_done_reg, frame_end, update;
  row_t             row_out_reg, col_out_reg, row_onehot, row_bits;

  gol_scan_prescaler #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .count(count),
    .tick (tick)
  );

  for (genvar gi = 0; gi < ROW_W; gi++) begin : g_onehot
    assign row_onehot[gi] = (row_idx_reg == 3'(gi));
  end

  assign row_bits  = grid_row(disp_grid_reg, row_idx_reg);
  assign frame_end = tick && (row_idx_reg == 3'd7);

  // The swap lands on the edge closing the frame_done cycle, after row 7's last output was sampled.
  assign update      = frame_done_reg && (bus.grid_valid || pending_reg);
  assign update_grid = bus.grid_valid ? bus.grid_in : pend_grid_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_BLANK;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BLANK: if (BLANK_CYCLES == 0 || count == BLANK_LAST) state_next = S_DRIVE;
      S_DRIVE: if (BLANK_CYCLES > 0 && tick) state_next = S_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx_reg    <= '0;
      frame_done_reg <= 1'b0;
      row_out_reg    <= ROW_IDLE;
      col_out_reg    <= COL_IDLE;
    end else begin
      if (tick) row_idx_reg <= row_idx_reg + 3'd1;
      frame_done_reg <= frame_end;
      if (state_reg == S_DRIVE) begin
        row_out_reg <= (ROW_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot;
        col_out_reg <= (COL_ACTIVE_LOW != 0) ? ~row_bits : row_bits;
      end else begin
        row_out_reg <= ROW_IDLE;
        col_out_reg <= COL_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_grid_reg <= '0;
      pend_grid_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      if (bus.grid_valid) pend_grid_reg <= bus.grid_in;
      if (update) disp_grid_reg <= update_grid;
      if (frame_done_reg) begin
        pending_reg <= 1'b0;
      end else if (bus.grid_valid) begin
        pending_reg <= 1'b1;
      end
    end
  end

`ifdef GOL_STABLE_DETECT_EN
  logic stable_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_reg <= 1'b0;
    end else if (update) begin
      stable_reg <= (update_grid == disp_grid_reg);
    end
  end

  assign bus.stable = stable_reg;
`else
  assign bus.stable = 1'b0;
`endif

  assign bus.row_out    = row_out_reg;
  assign bus.col_out    = col_out_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_gol_led_scan.sv
// Bench for gol_led_scan at SCAN_DIV=4, BLANK_CYCLES=1, active-high rows and columns.
// Define GOL_STABLE_DETECT_EN for both bench and RTL to cover the stable flag.
`timescale 1ns/1ps
module tb_gol_led_scan;
  import gol_pkg::*;

  localparam int    DIV   = 4;
  localparam int    BLANK = 1;
  localparam int    FRAME = 8 * DIV;
  localparam grid_t GLIDER = 64'h4020_E000_0000_0000;
  localparam grid_t ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam grid_t GRID_A = 64'h0102_0304_0506_0708;
  localparam grid_t GRID_B = 64'h8040_2010_0804_0201;
  localparam grid_t GRID_C = 64'hAA55_AA55_AA55_AA55;
  localparam grid_t GRID_D = 64'h1111_1111_1111_1111;
  localparam grid_t BLOCK  = 64'h0000_1818_0000_0000;
`ifdef GOL_STABLE_DETECT_EN
  localparam bit STAB_ON = 1'b1;
`else
  localparam bit STAB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  gol_led_scan_if bus();

  gol_led_scan #(
    .SCAN_DIV      (DIV),
    .BLANK_CYCLES  (BLANK),
    .ROW_ACTIVE_LOW(0),
    .COL_ACTIVE_LOW(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  bit    run = 1'b0;
  int    cyc = 0;
  grid_t disp_m = '0;
  grid_t pend_m = '0;
  bit    pend_v = 1'b0;
  bit    stable_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: cycles counted from reset release, swap decided on every 32nd cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc = 0; disp_m = '0; pend_v = 1'b0; stable_m = 1'b0;
    end else begin
      if (cyc > 0 && cyc % FRAME == 0) begin
        if (bus.grid_valid || pend_v) begin
          grid_t nxt;
          nxt = bus.grid_valid ? bus.grid_in : pend_m;
          if (STAB_ON) stable_m = (nxt == disp_m);
          disp_m = nxt;
        end
        pend_v = 1'b0;
      end else if (bus.grid_valid) begin
        pend_m = bus.grid_in;
        pend_v = 1'b1;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      row_t  er, ec;
      bit    ef;
      int    p, slot;
      grid_t sh;
      er = '0; ec = '0; ef = 1'b0;
      if (reset && cyc > 0) begin
        p    = (cyc - 1) % FRAME;
        slot = p / DIV;
        ef   = (p == FRAME - 1);
        if (p % DIV >= BLANK) begin
          er = row_t'(1) << slot;
          sh = disp_m >> (8 * (7 - slot));
          ec = sh[7:0];
        end
      end
      chk("row_out", bus.row_out, er);
      chk("col_out", bus.col_out, ec);
      chk("frame_done", bus.frame_done, ef);
      chk("stable", bus.stable, stable_m);
    end
  end

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.frame_done && n < 3 * FRAME);
    if (!bus.frame_done) chk("wait_frame_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_row(input row_t r, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (bus.row_out !== r && n < 3 * FRAME);
    if (bus.row_out !== r) chk("wait_row_timeout", bus.row_out, r);
  endtask

  task automatic strobe(input grid_t g);
    $display("strobe grid=%h at cycle %0d", g, cyc);
    bus.grid_in = g;
    bus.grid_valid = 1'b1;
    @(posedge clk); #1;
    bus.grid_valid = 1'b0;
  endtask

  initial begin
    int n;
    bus.grid_valid = 1'b0;
    bus.grid_in = '0;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b1;
    chk("reset_row", bus.row_out, 8'h00);
    chk("reset_col", bus.col_out, 8'h00);
    chk("reset_fd", bus.frame_done, 1'b0);
    reset = 1'b1;

    // glider shown from the frame after the first frame_done
    @(posedge clk); #1;
    strobe(GLIDER);
    wait_frame(n);
    chk("first_fd_latency", n, 30);
    chk("fd_on_row7", bus.row_out, 8'h80);
    wait_row(8'h01, n); chk("glider_row0_wait", n, 2); chk("glider_row0", bus.col_out, 8'h40);
    wait_row(8'h02, n); chk("glider_row1_wait", n, 4); chk("glider_row1", bus.col_out, 8'h20);
    wait_row(8'h04, n); chk("glider_row2", bus.col_out, 8'hE0);
    wait_row(8'h08, n); chk("glider_row3", bus.col_out, 8'h00);
    wait_frame(n);
    wait_frame(n);
    chk("frame_period", n, FRAME);

    // reset mid-frame while a lit row is driven
    wait_row(8'h04, n); chk("pre_reset_row2", bus.col_out, 8'hE0);
    reset = 1'b0;
    #1;
    chk("midreset_row", bus.row_out, 8'h00);
    chk("midreset_col", bus.col_out, 8'h00);
    chk("midreset_fd", bus.frame_done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_row(8'h01, n); chk("restart_row0_wait", n, 2); chk("restart_blank_grid", bus.col_out, 8'h00);

    // no tearing: new grid arrives while row 3 is driven
    strobe(GLIDER);
    wait_frame(n);
    wait_row(8'h08, n);
    strobe(ALL1);
    wait_row(8'h10, n); chk("no_tear_row4", bus.col_out, 8'h00);
    wait_frame(n);
    wait_row(8'h01, n); chk("all1_row0", bus.col_out, 8'hFF);

    // last strobe in a frame wins
    strobe(GRID_A);
    repeat (4) @(posedge clk);
    #1;
    strobe(GRID_B);
    wait_frame(n);
    wait_row(8'h01, n); chk("last_wins_row0", bus.col_out, 8'h80);
    wait_row(8'h02, n); chk("last_wins_row1", bus.col_out, 8'h40);

    // strobe on the frame_done cycle overrides the pending grid
    strobe(GRID_D);
    wait_frame(n);
    $display("strobe grid=%h at cycle %0d (frame_done)", GRID_C, cyc);
    bus.grid_in = GRID_C;
    bus.grid_valid = 1'b1;
    @(posedge clk); #1;
    bus.grid_valid = 1'b0;
    wait_row(8'h01, n); chk("coincide_row0", bus.col_out, 8'hAA);
    wait_frame(n);
    wait_row(8'h02, n); chk("coincide_hold_row1", bus.col_out, 8'h55);

    // stable flag across repeated and changed generations
    repeat (2) @(posedge clk);
    #1;
    strobe(BLOCK);
    wait_frame(n);
    repeat (3) @(posedge clk);
    #1;
    strobe(BLOCK);
    wait_frame(n);
    @(posedge clk); #1;
    chk("stable_same", bus.stable, STAB_ON);
    wait_row(8'h08, n); chk("block_row3", bus.col_out, 8'h18);
    strobe(GLIDER);
    wait_frame(n);
    @(posedge clk); #1;
    chk("stable_changed", bus.stable, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
